// File: rtl/io_bcd_display_pkg.sv
// Shared definitions for the output-port BCD display converter.
package io_bcd_display_pkg;

  // Converter FSM encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Nibble the downstream seven-segment decoder renders as all segments off.
  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  // Largest value representable in 'digits' decimal digits (10^digits - 1),
  // computed as a 32-bit constant.
  function automatic logic [31:0] max_value(input int digits);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

  // Limit for the default six-digit display.
  localparam logic [31:0] MAX_VALUE = max_value(6);

endpackage

// File: rtl/io_bcd_display_bcd_add3.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module io_bcd_display_bcd_add3 (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Conditional +3 correction; no carry leaves the nibble.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/io_bcd_display.sv
// Sequential binary-to-BCD converter for the out_port display.
// Watches value_in; whenever it differs from the last captured value, runs a
// shift-and-add-3 conversion over IN_WIDTH cycles and publishes DIGITS packed
// BCD nibbles. Values that do not fit in DIGITS decimal digits blank the
// display (every nibble 4'hF) and raise overflow. The nibbles of bcd_out feed
// the per-digit sevenseg decoders at the integrating level.
//
// Handshake: there is no ready input. busy is high from the capture edge up
// to the publish edge; done is a one-cycle pulse on the cycle after the edge
// that updates bcd_out/overflow, and those outputs are otherwise stable.
module io_bcd_display
  import io_bcd_display_pkg::*;
#(
  parameter int IN_WIDTH = 20,
  parameter int DIGITS   = 6
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [31:0]         value_in,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output state_e              state_dbg
);

  localparam int          SW    = 4 * DIGITS;
  localparam int          CW    = $clog2(IN_WIDTH + 1);
  localparam logic [31:0] LIMIT = max_value(DIGITS);

  state_e              state_q;
  state_e              state_d;
  logic [31:0]         last_val;
  logic [IN_WIDTH-1:0] bin_q;
  logic [SW-1:0]       scr_q;
  logic [SW-1:0]       scr_adj;
  logic [CW-1:0]       cnt_q;
  logic                ovf_pend;
  logic                capture;
  logic                last_shift;
  logic                out_of_range;

  assign capture      = (value_in != last_val);
  assign last_shift   = (cnt_q == CW'(IN_WIDTH - 1));
  assign out_of_range = (value_in[31:IN_WIDTH] != '0) || (value_in > LIMIT);
  assign state_dbg    = state_q;

  // Per-digit +3 correction applied to the scratch register before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    io_bcd_display_bcd_add3 u_add3 (
      .digit_in  (scr_q[4*g +: 4]),
      .digit_out (scr_adj[4*g +: 4])
    );
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: capture, shift sequence and result publication.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_val <= '0;
      bin_q    <= '0;
      scr_q    <= '0;
      cnt_q    <= '0;
      ovf_pend <= 1'b0;
      bcd_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (capture) begin
            last_val <= value_in;
            bin_q    <= value_in[IN_WIDTH-1:0];
            scr_q    <= '0;
            cnt_q    <= '0;
            ovf_pend <= out_of_range;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          {scr_q, bin_q} <= {scr_adj[SW-2:0], bin_q, 1'b0};
          cnt_q          <= cnt_q + CW'(1);
        end
        DONE: begin
          bcd_out  <= ovf_pend ? {DIGITS{BLANK_NIBBLE}} : scr_q;
          overflow <= ovf_pend;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
